// File: rtl/dcsformer_driver.sv
// Host-side initiator for the DCSformer attention core: buffers one payload,
// streams inputs then weights to the core, and forwards the eight results upstream.
module dcsformer_driver #(
    parameter int N_IN    = 128,
    parameter int N_W     = 8,
    parameter int TIMEOUT = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [7:0]  ld_data,
    output logic        ld_ready,
    input  logic        start,
    output logic        busy,
    output logic        i_valid,
    output logic [7:0]  i_data,
    input  logic        w_ready,
    output logic        w_valid,
    output logic [7:0]  w_data,
    input  logic        o_valid,
    input  logic [31:0] o_data,
    output logic        res_valid,
    output logic [31:0] res_data,
    output logic [2:0]  res_idx,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code
);

    localparam int N_TOT = N_IN + N_W;
    localparam int PTR_W = $clog2(N_TOT + 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_SEND_X  = 3'd1;
    localparam logic [2:0] S_WAIT_WR = 3'd2;
    localparam logic [2:0] S_SEND_W  = 3'd3;
    localparam logic [2:0] S_COLLECT = 3'd4;

    logic [7:0]       mem_q [N_TOT];
    logic [2:0]       state_q, state_d;
    logic [PTR_W-1:0] ld_ptr_q, ld_ptr_d;
    logic [PTR_W-1:0] cnt_q, cnt_d;
    logic [15:0]      wait_q, wait_d;
    logic [2:0]       k_q, k_d;
    logic             i_valid_q, i_valid_d;
    logic [7:0]       i_data_q, i_data_d;
    logic             w_valid_q, w_valid_d;
    logic [7:0]       w_data_q, w_data_d;
    logic             res_valid_q, res_valid_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [2:0]       res_idx_q, res_idx_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic             full;
    logic             ld_we;

    assign full  = (ld_ptr_q == PTR_W'(N_TOT));
    assign ld_we = (state_q == S_IDLE) && !full && ld_valid;

    always_ff @(posedge clk) begin
        if (ld_we) begin
            mem_q[ld_ptr_q] <= ld_data;
        end
    end

    // cnt_q holds the index of the next byte to present while streaming.
    always_comb begin
        state_d     = state_q;
        ld_ptr_d    = ld_ptr_q;
        cnt_d       = cnt_q;
        wait_d      = wait_q;
        k_d         = k_q;
        i_valid_d   = 1'b0;
        i_data_d    = '0;
        w_valid_d   = 1'b0;
        w_data_d    = '0;
        res_valid_d = 1'b0;
        res_data_d  = '0;
        res_idx_d   = '0;
        done_d      = 1'b0;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        if (ld_we) begin
            ld_ptr_d = ld_ptr_q + PTR_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (start && full) begin
                    state_d    = S_SEND_X;
                    cnt_d      = PTR_W'(1);
                    i_valid_d  = 1'b1;
                    i_data_d   = mem_q[0];
                    err_code_d = '0;
                end
            end
            S_SEND_X: begin
                if (cnt_q == PTR_W'(N_IN)) begin
                    state_d = S_WAIT_WR;
                    wait_d  = '0;
                end else begin
                    i_valid_d = 1'b1;
                    i_data_d  = mem_q[cnt_q];
                    cnt_d     = cnt_q + PTR_W'(1);
                end
            end
            S_WAIT_WR: begin
                if (w_ready) begin
                    state_d   = S_SEND_W;
                    cnt_d     = PTR_W'(1);
                    w_valid_d = 1'b1;
                    w_data_d  = mem_q[N_IN];
                end else if (wait_q == 16'(TIMEOUT)) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    err_code_d = 2'd1;
                    ld_ptr_d   = '0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            S_SEND_W: begin
                if (cnt_q == PTR_W'(N_W)) begin
                    state_d = S_COLLECT;
                    wait_d  = '0;
                    k_d     = '0;
                end else begin
                    w_valid_d = 1'b1;
                    w_data_d  = mem_q[PTR_W'(N_IN) + cnt_q];
                    cnt_d     = cnt_q + PTR_W'(1);
                end
            end
            S_COLLECT: begin
                if (o_valid) begin
                    res_valid_d = 1'b1;
                    res_data_d  = o_data;
                    res_idx_d   = k_q;
                    k_d         = k_q + 3'd1;
                    wait_d      = '0;
                    if (k_q == 3'(N_W - 1)) begin
                        state_d  = S_IDLE;
                        done_d   = 1'b1;
                        ld_ptr_d = '0;
                    end
                end else if (wait_q == 16'(TIMEOUT)) begin
                    state_d    = S_IDLE;
                    err_d      = 1'b1;
                    err_code_d = 2'd2;
                    ld_ptr_d   = '0;
                end else begin
                    wait_d = wait_q + 16'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ld_ptr_q    <= '0;
            cnt_q       <= '0;
            wait_q      <= '0;
            k_q         <= '0;
            i_valid_q   <= 1'b0;
            i_data_q    <= '0;
            w_valid_q   <= 1'b0;
            w_data_q    <= '0;
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_idx_q   <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            err_code_q  <= '0;
        end else begin
            state_q     <= state_d;
            ld_ptr_q    <= ld_ptr_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            k_q         <= k_d;
            i_valid_q   <= i_valid_d;
            i_data_q    <= i_data_d;
            w_valid_q   <= w_valid_d;
            w_data_q    <= w_data_d;
            res_valid_q <= res_valid_d;
            res_data_q  <= res_data_d;
            res_idx_q   <= res_idx_d;
            done_q      <= done_d;
            err_q       <= err_d;
            err_code_q  <= err_code_d;
        end
    end

    assign ld_ready  = (state_q == S_IDLE) && !full;
    assign busy      = (state_q != S_IDLE);
    assign i_valid   = i_valid_q;
    assign i_data    = i_data_q;
    assign w_valid   = w_valid_q;
    assign w_data    = w_data_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_idx   = res_idx_q;
    assign done      = done_q;
    assign err       = err_q;
    assign err_code  = err_code_q;

endmodule

// File: tb/tb_dcsformer_driver.sv
// Scoreboard bench for dcsformer_driver: dut_a uses the default timeout,
// dut_b a short timeout for the abort scenarios.
module tb_dcsformer_driver;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ld_valid = 1'b0;
    logic [7:0]  ld_data = '0;
    logic        start = 1'b0;
    logic        w_ready = 1'b0;
    logic        o_valid = 1'b0;
    logic [31:0] o_data = '0;

    logic        a_ld_ready, a_busy, a_i_valid, a_w_valid, a_res_valid, a_done, a_err;
    logic [7:0]  a_i_data, a_w_data;
    logic [31:0] a_res_data;
    logic [2:0]  a_res_idx;
    logic [1:0]  a_err_code;
    logic        b_ld_ready, b_busy, b_i_valid, b_w_valid, b_res_valid, b_done, b_err;
    logic [7:0]  b_i_data, b_w_data;
    logic [31:0] b_res_data;
    logic [2:0]  b_res_idx;
    logic [1:0]  b_err_code;

    logic        sel_b = 1'b0;
    logic        m_ld_ready, m_busy, m_i_valid, m_w_valid, m_res_valid, m_done, m_err;
    logic [7:0]  m_i_data, m_w_data;
    logic [31:0] m_res_data;
    logic [2:0]  m_res_idx;
    logic [1:0]  m_err_code;

    int n_checks = 0;
    int n_fail = 0;
    logic        sb_on = 1'b0;
    logic [7:0]  exp_i [$];
    logic [7:0]  exp_w [$];
    logic [34:0] exp_res [$];
    logic [7:0]  pay [136];
    logic [7:0]  ei, ew;
    logic [34:0] er;

    always #5 clk = ~clk;

    dcsformer_driver #(.N_IN(128), .N_W(8), .TIMEOUT(1023)) dut_a (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(a_ld_ready),
        .start(start), .busy(a_busy), .i_valid(a_i_valid), .i_data(a_i_data),
        .w_ready(w_ready), .w_valid(a_w_valid), .w_data(a_w_data),
        .o_valid(o_valid), .o_data(o_data), .res_valid(a_res_valid), .res_data(a_res_data),
        .res_idx(a_res_idx), .done(a_done), .err(a_err), .err_code(a_err_code)
    );

    dcsformer_driver #(.N_IN(128), .N_W(8), .TIMEOUT(15)) dut_b (
        .clk(clk), .rst_n(rst_n), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(b_ld_ready),
        .start(start), .busy(b_busy), .i_valid(b_i_valid), .i_data(b_i_data),
        .w_ready(w_ready), .w_valid(b_w_valid), .w_data(b_w_data),
        .o_valid(o_valid), .o_data(o_data), .res_valid(b_res_valid), .res_data(b_res_data),
        .res_idx(b_res_idx), .done(b_done), .err(b_err), .err_code(b_err_code)
    );

    always_comb begin
        m_ld_ready  = sel_b ? b_ld_ready  : a_ld_ready;
        m_busy      = sel_b ? b_busy      : a_busy;
        m_i_valid   = sel_b ? b_i_valid   : a_i_valid;
        m_i_data    = sel_b ? b_i_data    : a_i_data;
        m_w_valid   = sel_b ? b_w_valid   : a_w_valid;
        m_w_data    = sel_b ? b_w_data    : a_w_data;
        m_res_valid = sel_b ? b_res_valid : a_res_valid;
        m_res_data  = sel_b ? b_res_data  : a_res_data;
        m_res_idx   = sel_b ? b_res_idx   : a_res_idx;
        m_done      = sel_b ? b_done      : a_done;
        m_err       = sel_b ? b_err       : a_err;
        m_err_code  = sel_b ? b_err_code  : a_err_code;
    end

    // Scoreboard: every strobed byte/result must match the head of its queue.
    always @(negedge clk) begin
        if (sb_on && rst_n) begin
            n_checks++;
            if (m_i_valid) begin
                if (exp_i.size() == 0) begin
                    n_fail++; $display("FAIL i_data: got %0d, required no byte", m_i_data);
                end else begin
                    ei = exp_i.pop_front();
                    if (m_i_data !== ei) begin n_fail++; $display("FAIL i_data: got %0d, required %0d", m_i_data, ei); end
                end
            end else if (m_i_data !== 8'd0) begin
                n_fail++; $display("FAIL i_data_idle: got %0d, required 0", m_i_data);
            end
            n_checks++;
            if (m_w_valid) begin
                if (exp_w.size() == 0) begin
                    n_fail++; $display("FAIL w_data: got %0d, required no byte", m_w_data);
                end else begin
                    ew = exp_w.pop_front();
                    if (m_w_data !== ew) begin n_fail++; $display("FAIL w_data: got %0d, required %0d", m_w_data, ew); end
                end
            end else if (m_w_data !== 8'd0) begin
                n_fail++; $display("FAIL w_data_idle: got %0d, required 0", m_w_data);
            end
            if (m_res_valid) begin
                n_checks++;
                if (exp_res.size() == 0) begin
                    n_fail++; $display("FAIL res: got idx %0d data %0d, required none", m_res_idx, m_res_data);
                end else begin
                    er = exp_res.pop_front();
                    if ({m_res_idx, m_res_data} !== er) begin
                        n_fail++;
                        $display("FAIL res: got idx %0d data %0d, required idx %0d data %0d",
                                 m_res_idx, m_res_data, er[34:32], er[31:0]);
                    end
                end
            end
        end
    end

    task automatic apply_reset();
        rst_n = 1'b0; ld_valid = 1'b0; start = 1'b0; w_ready = 1'b0; o_valid = 1'b0; o_data = '0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        @(posedge clk); #1;
        exp_i.delete(); exp_w.delete(); exp_res.delete();
    endtask

    task automatic set_payload(input bit rnd);
        for (int i = 0; i < 128; i++) pay[i] = rnd ? 8'($urandom) : 8'(i + 1);
        for (int m = 0; m < 8; m++) pay[128 + m] = rnd ? 8'($urandom) : 8'(m + 1);
    endtask

    task automatic load_bytes(input int from, input int upto);
        for (int i = from; i < upto; i++) begin
            ld_valid = 1'b1; ld_data = pay[i];
            @(posedge clk); #1;
        end
        ld_valid = 1'b0; ld_data = '0;
    endtask

    task automatic stream_x(input bit early_wr);
        int cnt;
        for (int i = 0; i < 128; i++) exp_i.push_back(pay[i]);
        for (int m = 0; m < 8; m++) exp_w.push_back(pay[128 + m]);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        cnt = 0;
        for (int n = 0; n < 128; n++) begin
            if (m_i_valid === 1'b1) cnt++;
            if (early_wr && n == 127) w_ready = 1'b1;
            @(posedge clk); #1;
            w_ready = 1'b0;
        end
        n_checks++;
        if (cnt != 128) begin n_fail++; $display("FAIL i_valid_span: got %0d cycles, required 128", cnt); end
        n_checks++;
        if (m_i_valid !== 1'b0 || m_busy !== 1'b1) begin
            n_fail++; $display("FAIL after_x: got i_valid %b busy %b, required 0 1", m_i_valid, m_busy);
        end
    endtask

    task automatic give_w_ready(input int delay);
        int pre;
        int cnt;
        pre = 0;
        repeat (delay) begin
            if (m_w_valid === 1'b1) pre++;
            @(posedge clk); #1;
        end
        w_ready = 1'b1;
        @(posedge clk); #1;
        w_ready = 1'b0;
        cnt = 0;
        for (int m = 0; m < 8; m++) begin
            if (m_w_valid === 1'b1) cnt++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (pre != 0) begin n_fail++; $display("FAIL w_early: got %0d w_valid cycles, required 0", pre); end
        n_checks++;
        if (cnt != 8 || m_w_valid !== 1'b0) begin
            n_fail++; $display("FAIL w_valid_span: got %0d cycles (tail %b), required 8 (tail 0)", cnt, m_w_valid);
        end
    endtask

    task automatic give_results(input int nres, input bit gappy, input logic [31:0] base, input bit rnd);
        logic [31:0] d;
        int g;
        for (int k = 0; k < nres; k++) begin
            g = !gappy ? 0 : ((k % 3 == 0) ? 0 : (k % 3 == 1) ? 3 : 20);
            repeat (g) begin @(posedge clk); #1; end
            d = rnd ? $urandom : base + 32'(k);
            o_valid = 1'b1; o_data = d;
            exp_res.push_back({3'(k), d});
            @(posedge clk); #1;
            o_valid = 1'b0; o_data = '0;
            n_checks++;
            if (m_done !== (k == 7)) begin
                n_fail++; $display("FAIL done_at_res%0d: got %b, required %b", k, m_done, (k == 7));
            end
        end
    endtask

    task automatic check_drained(input string tag);
        n_checks++;
        if (exp_i.size() + exp_w.size() + exp_res.size() != 0) begin
            n_fail++;
            $display("FAIL drained_%s: got %0d/%0d/%0d pending, required 0/0/0",
                     tag, exp_i.size(), exp_w.size(), exp_res.size());
        end
    endtask

    task automatic check_done_tail();
        n_checks++;
        if (m_busy !== 1'b0 || m_res_idx !== 3'd7 || m_res_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL done_cycle: got busy %b res_valid %b idx %0d, required 0 1 7", m_busy, m_res_valid, m_res_idx);
        end
        @(posedge clk); #1;
        n_checks++;
        if (m_done !== 1'b0 || m_ld_ready !== 1'b1 || m_err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_done: got done %b ld_ready %b err %b, required 0 1 0", m_done, m_ld_ready, m_err);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        #2;
        n_checks++;
        if ({a_busy, a_i_valid, a_i_data, a_w_valid, a_w_data, a_res_valid, a_res_data,
             a_res_idx, a_done, a_err, a_err_code} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: got nonzero output, required all 0");
        end
        n_checks++;
        if (a_ld_ready !== 1'b1 || b_ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL reset_ld_ready: got %b %b, required 1 1", a_ld_ready, b_ld_ready);
        end
        apply_reset();
    endtask

    task automatic test_basic();
        sel_b = 1'b0; sb_on = 1'b1;
        apply_reset();
        set_payload(1'b0);
        load_bytes(0, 136);
        stream_x(1'b0);
        give_w_ready(5);
        give_results(8, 1'b0, 32'd100, 1'b0);
        n_checks++;
        if (m_res_data !== 32'd107) begin n_fail++; $display("FAIL basic_last: got %0d, required 107", m_res_data); end
        check_done_tail();
        check_drained("basic");
    endtask

    task automatic test_gaps();
        sel_b = 1'b0; sb_on = 1'b1;
        set_payload(1'b1);
        load_bytes(0, 136);
        stream_x(1'b1);
        give_w_ready(2);
        give_results(8, 1'b1, 32'd0, 1'b1);
        n_checks++;
        if (m_err_code !== 2'd0) begin n_fail++; $display("FAIL gaps_err_code: got %0d, required 0", m_err_code); end
        check_done_tail();
        check_drained("gaps");
    endtask

    task automatic test_wr_timeout();
        int found;
        int wv;
        logic [1:0] code;
        sel_b = 1'b1; sb_on = 1'b1;
        apply_reset();
        set_payload(1'b1);
        load_bytes(0, 136);
        stream_x(1'b0);
        found = 0; wv = 0; code = '0;
        for (int c = 1; c <= 30; c++) begin
            @(posedge clk); #1;
            if (m_w_valid === 1'b1) wv++;
            if (m_err === 1'b1 && found == 0) begin
                found = c; code = m_err_code;
                n_checks++;
                if (m_busy !== 1'b0) begin n_fail++; $display("FAIL wr_to_busy: got %b, required 0", m_busy); end
            end
        end
        n_checks++;
        if (found != 16) begin n_fail++; $display("FAIL wr_to_cycle: got %0d, required 16", found); end
        n_checks++;
        if (code !== 2'd1 || m_err_code !== 2'd1) begin
            n_fail++; $display("FAIL wr_to_code: got %0d/%0d, required 1/1", code, m_err_code);
        end
        n_checks++;
        if (wv != 0 || m_ld_ready !== 1'b1) begin
            n_fail++; $display("FAIL wr_to_after: got w_valid %0d ld_ready %b, required 0 1", wv, m_ld_ready);
        end
        exp_w.delete();
        check_drained("wr_to");
    endtask

    task automatic test_short_results();
        int found;
        int dn;
        int ec;
        sel_b = 1'b1; sb_on = 1'b1;
        apply_reset();
        set_payload(1'b0);
        load_bytes(0, 136);
        stream_x(1'b0);
        give_w_ready(3);
        give_results(5, 1'b0, 32'd200, 1'b0);
        found = 0; dn = 0; ec = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            if (m_done === 1'b1) dn++;
            if (m_err === 1'b1) begin
                ec++;
                if (found == 0) found = c;
            end
        end
        n_checks++;
        if (found != 16 || ec != 1) begin
            n_fail++; $display("FAIL col_to_cycle: got cycle %0d pulses %0d, required 16 1", found, ec);
        end
        n_checks++;
        if (m_err_code !== 2'd2 || dn != 0) begin
            n_fail++; $display("FAIL col_to_code: got code %0d done %0d, required 2 0", m_err_code, dn);
        end
        n_checks++;
        if (m_ld_ready !== 1'b1 || m_busy !== 1'b0) begin
            n_fail++; $display("FAIL col_to_idle: got ld_ready %b busy %b, required 1 0", m_ld_ready, m_busy);
        end
        check_drained("col_to");
    endtask

    task automatic test_not_full();
        int act;
        sel_b = 1'b0; sb_on = 1'b1;
        apply_reset();
        set_payload(1'b1);
        load_bytes(0, 100);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        act = 0;
        for (int c = 0; c < 10; c++) begin
            if (m_busy !== 1'b0 || m_i_valid !== 1'b0 || m_err !== 1'b0) act++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (act != 0) begin n_fail++; $display("FAIL early_start: got %0d active cycles, required 0", act); end
        load_bytes(100, 136);
        ld_valid = 1'b1; ld_data = 8'hEE;
        @(posedge clk); #1;
        n_checks++;
        if (m_ld_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b, required 0", m_ld_ready); end
        @(posedge clk); #1;
        ld_valid = 1'b0; ld_data = '0;
        stream_x(1'b0);
        give_w_ready(1);
        give_results(8, 1'b0, 32'd300, 1'b0);
        check_done_tail();
        check_drained("not_full");
    endtask

    task automatic test_reset_mid();
        sel_b = 1'b0; sb_on = 1'b1;
        apply_reset();
        set_payload(1'b1);
        load_bytes(0, 136);
        stream_x(1'b0);
        w_ready = 1'b1;
        @(posedge clk); #1;
        w_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (m_w_valid !== 1'b1 || m_w_data !== pay[131]) begin
            n_fail++; $display("FAIL mid_w3: got %b/%0d, required 1/%0d", m_w_valid, m_w_data, pay[131]);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (m_w_valid !== 1'b0 || m_busy !== 1'b0 || m_ld_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_reset: got w_valid %b busy %b ld_ready %b, required 0 0 1", m_w_valid, m_busy, m_ld_ready);
        end
        apply_reset();
        set_payload(1'b1);
        load_bytes(0, 136);
        stream_x(1'b0);
        give_w_ready(4);
        give_results(8, 1'b0, 32'd0, 1'b1);
        check_done_tail();
        check_drained("reset_mid");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no completion, required $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_gaps();
        test_wr_timeout();
        test_short_results();
        test_not_full();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
